// File: rtl/phy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : phy_pkg
// Brief    : Shared lane constants and types for the serial lane TX/RX pair.
// Revision : 1.0 - initial release
// ============================================================================
package phy_pkg;

  // Width of one lane symbol
  localparam int unsigned SYM_W = 8;

  // Alignment / idle symbol inserted by the transmitter
  localparam logic [SYM_W-1:0] COM = 8'hBC;

  // Receiver alignment states
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOCK   = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

endpackage : phy_pkg
`default_nettype wire

// File: rtl/sp_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : sp_shift_reg
// Brief    : MSB-first serial shift register exposing the 8-bit window formed
//            by the last seven stored bits plus the bit being sampled now.
// Revision : 1.0 - initial release
// ============================================================================
module sp_shift_reg
  import phy_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  output logic [SYM_W-1:0] window
);

  // The oldest bit of the window leaves on the next edge, so only the
  // younger seven bits ever need to be stored.
  logic [SYM_W-2:0] hist_q;
  logic [SYM_W-2:0] hist_d;

  // Window = history with the incoming bit appended; next history drops its MSB
  always_comb begin
    window = {hist_q, din};
    hist_d = window[SYM_W-2:0];
  end

  // History register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule : sp_shift_reg
`default_nettype wire

// File: rtl/serial_to_parallel.sv
`default_nettype none
// ============================================================================
// Module   : serial_to_parallel
// Brief    : Lane receiver. Deserializes MSB-first bits into bytes, hunts for
//            the COM symbol to find byte boundaries, goes active after
//            ALIGN_COUNT consecutive aligned COMs and then presents each byte
//            with a valid flag that is low for idle COM symbols.
// Revision : 1.0 - initial release
// ============================================================================
module serial_to_parallel #(
  parameter int unsigned ALIGN_COUNT = 4   // 1..15
) (
  input  logic       clk32f,
  input  logic       reset,        // asynchronous, active low
  input  logic       in,
  output logic [7:0] out,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  import phy_pkg::*;

  localparam logic [3:0] ALIGN_TARGET = 4'(ALIGN_COUNT);

  logic [SYM_W-1:0] win;

  rx_state_e        state_q,  state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]       bc_count_q, bc_count_d;
  logic [SYM_W-1:0] out_q,    out_d;
  logic             valid_q,  valid_d;
  logic             strobe_q, strobe_d;
  logic             active_q, active_d;

  logic             byte_done;
  logic             is_com;
  logic [3:0]       bc_next;

  sp_shift_reg u_shift (
    .clk    (clk32f),
    .rst_n  (reset),
    .din    (in),
    .window (win)
  );

  // Alignment FSM, counters and output data next-state
  always_comb begin
    byte_done  = (bit_cnt_q == 3'd7);
    is_com     = (win == COM);
    bc_next    = bc_count_q + 4'd1;

    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q + 3'd1;
    bc_count_d = bc_count_q;
    out_d      = out_q;
    valid_d    = valid_q;
    strobe_d   = 1'b0;

    unique case (state_q)
      HUNT: begin
        // Bit-granular search: a match defines the byte boundary
        if (is_com) begin
          bit_cnt_d  = 3'd0;
          bc_count_d = 4'd1;
          state_d    = (ALIGN_COUNT == 1) ? ACTIVE : LOCK;
        end
      end
      LOCK: begin
        if (byte_done) begin
          if (is_com) begin
            bc_count_d = bc_next;
            if (bc_next == ALIGN_TARGET) begin
              state_d = ACTIVE;
            end
          end else begin
            // Wrong phase or broken COM run: restart the search
            bc_count_d = 4'd0;
            state_d    = HUNT;
          end
        end
      end
      ACTIVE: begin
        if (byte_done) begin
          out_d    = win;
          valid_d  = !is_com;
          strobe_d = 1'b1;
        end
      end
      default: begin
        state_d    = HUNT;
        bc_count_d = 4'd0;
      end
    endcase

    active_d = (state_d == ACTIVE);
  end

  // State and registered outputs, cleared asynchronously
  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      state_q    <= HUNT;
      bit_cnt_q  <= 3'd0;
      bc_count_q <= 4'd0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      strobe_q   <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bc_count_q <= bc_count_d;
      out_q      <= out_d;
      valid_q    <= valid_d;
      strobe_q   <= strobe_d;
      active_q   <= active_d;
    end
  end

  assign out         = out_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;

endmodule : serial_to_parallel
`default_nettype wire

// File: tb/tb_serial_to_parallel.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_to_parallel
// Brief    : Self-checking bench for serial_to_parallel. A sample-indexed
//            reference model predicts every output after every clock edge;
//            directed checks cover the named scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_to_parallel;

  localparam logic [7:0] C_COM   = 8'hBC;
  localparam int         C_ALIGN = 4;

  logic       clk32f;
  logic       reset;
  logic       in;
  logic [7:0] out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int total;
  int bad;

  // Reference model: all bits since reset, indexed by sample number
  bit         m_bits[$];
  int         m_mode;      // 0 searching, 1 confirming, 2 locked
  int         m_anchor;    // sample index of the last COM that set the phase
  int         m_cnt;
  logic [7:0] m_out;
  logic       m_valid;
  logic       m_strobe;
  logic       m_active;

  serial_to_parallel #(.ALIGN_COUNT(C_ALIGN)) dut (
    .clk32f      (clk32f),
    .reset       (reset),
    .in          (in),
    .out         (out),
    .valid_out   (valid_out),
    .byte_strobe (byte_strobe),
    .active      (active)
  );

  initial clk32f = 1'b0;
  always #5 clk32f = ~clk32f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_mode   = 0;
    m_anchor = 0;
    m_cnt    = 0;
    m_out    = 8'h00;
    m_valid  = 1'b0;
    m_strobe = 1'b0;
    m_active = 1'b0;
  endtask

  // Apply the receive rules to the window ending at the newest sample
  task automatic model_step(input bit b);
    int         k;
    logic [7:0] win;
    m_bits.push_back(b);
    k   = m_bits.size() - 1;
    win = 8'h00;
    for (int j = 7; j >= 0; j--) begin
      win = {win[6:0], ((k - j) >= 0) ? m_bits[k - j] : 1'b0};
    end
    m_strobe = 1'b0;
    if (m_mode == 0) begin
      if (win == C_COM) begin
        m_anchor = k;
        m_cnt    = 1;
        m_mode   = (C_ALIGN == 1) ? 2 : 1;
      end
    end else if (((k - m_anchor) % 8) == 0) begin
      if (m_mode == 1) begin
        if (win == C_COM) begin
          m_cnt = m_cnt + 1;
          if (m_cnt == C_ALIGN) m_mode = 2;
        end else begin
          m_cnt  = 0;
          m_mode = 0;
        end
      end else begin
        m_out    = win;
        m_valid  = (win != C_COM);
        m_strobe = 1'b1;
      end
    end
    m_active = (m_mode == 2);
  endtask

  task automatic check_all();
    chk("out",         32'(out),         32'(m_out));
    chk("valid_out",   32'(valid_out),   32'(m_valid));
    chk("byte_strobe", 32'(byte_strobe), 32'(m_strobe));
    chk("active",      32'(active),      32'(m_active));
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk32f);
    in = b;
    @(posedge clk32f);
    model_step(b);
    #1;
    check_all();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  // Asynchronous reset pulse placed away from the clock edges
  task automatic pulse_reset(input string tag);
    @(posedge clk32f);
    #3;
    reset = 1'b0;
    #1;
    chk({tag, "_out"},    32'(out),         32'h0);
    chk({tag, "_valid"},  32'(valid_out),   32'h0);
    chk({tag, "_strobe"}, 32'(byte_strobe), 32'h0);
    chk({tag, "_active"}, 32'(active),      32'h0);
    model_reset();
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] r;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    in    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk32f);
    pulse_reset("por");

    // Junk 101 then four COMs: active exactly on the last bit of the 4th
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_byte(C_COM); send_byte(C_COM); send_byte(C_COM);
    for (int i = 7; i >= 1; i--) send_bit(C_COM[i]);
    chk("align_before_last_bit", 32'(active), 32'h0);
    send_bit(C_COM[0]);
    chk("align_active", 32'(active), 32'h1);

    // Data bytes EE then CC
    send_byte(8'hEE);
    chk("ee_out", 32'(out), 32'hEE);
    chk("ee_valid", 32'(valid_out), 32'h1);
    chk("ee_strobe", 32'(byte_strobe), 32'h1);
    send_byte(8'hCC);
    chk("cc_out", 32'(out), 32'hCC);
    chk("cc_strobe", 32'(byte_strobe), 32'h1);

    // Idle COM between two data bytes
    send_byte(8'hDD);
    chk("dd_valid", 32'(valid_out), 32'h1);
    send_byte(C_COM);
    chk("com_out", 32'(out), 32'hBC);
    chk("com_valid", 32'(valid_out), 32'h0);
    chk("com_strobe", 32'(byte_strobe), 32'h1);
    send_byte(8'h99);
    chk("99_out", 32'(out), 32'h99);
    chk("99_valid", 32'(valid_out), 32'h1);

    // Mid-byte reset while active
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    pulse_reset("mid");

    // Broken COM run falls back to HUNT, then realigns
    send_byte(C_COM); send_byte(C_COM); send_byte(C_COM);
    send_byte(8'h55);
    chk("broken_run_active", 32'(active), 32'h0);
    for (int i = 0; i < 4; i++) send_byte(C_COM);
    chk("realign_active", 32'(active), 32'h1);

    // False COM straddling a byte boundary must not persist
    pulse_reset("fc");
    send_byte(8'h0B); send_byte(8'hC0); send_byte(8'h00);
    chk("false_com_active", 32'(active), 32'h0);
    for (int i = 0; i < 4; i++) send_byte(C_COM);
    chk("false_com_realign", 32'(active), 32'h1);
    send_byte(8'h3A);
    chk("false_com_data", 32'(out), 32'h3A);

    // Randomized: random junk bits, COM preamble, mixed data/idle bytes
    for (int it = 0; it < 4; it++) begin
      pulse_reset("rnd");
      for (int i = 0; i < int'($urandom_range(20, 0)); i++) send_bit(1'($urandom));
      for (int i = 0; i < 5; i++) send_byte(C_COM);
      for (int i = 0; i < 40; i++) begin
        r = ($urandom_range(3, 0) == 0) ? C_COM : 8'($urandom);
        send_byte(r);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_serial_to_parallel
`default_nettype wire

// File: doc/serial_to_parallel.md
# serial_to_parallel

Receive-side counterpart of the parallel-to-serial lane transmitter. Deserializes one MSB-first serial bit per clock into 8-bit symbols, finds symbol boundaries by hunting for the COM symbol (8'hBC), and declares the lane active after consecutive aligned COMs. Once active, each received byte is presented on a parallel output with a valid flag that is low for idle COM symbols. Sits between the serial lane and the byte-wide receive path.

## Interface
- `COM`, 8'hBC: alignment/idle symbol.
- `ALIGN_COUNT`, 4: consecutive aligned COMs required to go active (range 1–15).
- `clk32f`  input  1  bit clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `in`  input  1  serial data, MSB first, sampled on rising `clk32f`.
- `out`  output  8  last received byte (registered).
- `valid_out`  output  1  `out` carries data (not COM); registered with `out`.
- `byte_strobe`  output  1  one-cycle pulse: `out`/`valid_out` just updated.
- `active`  output  1  lane aligned (state == ACTIVE).

## Operation
- Window `w = {shift[6:0], in}`; every edge `shift <= w`.
- `bit_cnt` (3 b): bits of current byte already received; byte completes on the edge where `bit_cnt == 7`, then `bit_cnt <= 0`, else `+1` (wraps naturally).
- `bc_count` (4 b): consecutive aligned COMs.
- States:
  - HUNT: every edge compare `w == COM` (bit-granular search). Match: `bit_cnt <= 0`, `bc_count <= 1`; to ACTIVE if `ALIGN_COUNT == 1`, else LOCK.
  - LOCK: at byte completion only. `w == COM`: `bc_count + 1`; equals `ALIGN_COUNT` -> ACTIVE. Otherwise -> HUNT, `bc_count <= 0`. Non-boundary edges: no state change.
  - ACTIVE: at byte completion: `out <= w`, `valid_out <= (w != COM)`, `byte_strobe <= 1`. Stays in ACTIVE until reset (no loss-of-lock detection in this block).
- The COM that completes alignment is not presented on `out`; the first strobe is for the next byte.
- `out`/`valid_out` hold between strobes; `byte_strobe` is 0 on all other cycles, and is never 1 outside ACTIVE.
- `active` registered: 1 from the edge that enters ACTIVE.
- Reset (asynchronous, any time, including mid-byte): state HUNT; `shift`, `bit_cnt`, `bc_count`, `out`, `valid_out`, `byte_strobe`, `active` all 0. Alignment restarts from scratch after release.

## Timing
- Byte latency: `out` updates on the same edge that samples the byte's 8th bit; visible one clock-to-q later.
- Strobe period in ACTIVE: exactly 8 cycles.
- Minimum alignment time from reset release: `8 * ALIGN_COUNT` cycles of COM stream (phase-aligned input).
- False match in HUNT (COM pattern straddling two bytes) locks at wrong phase; the next boundary compare fails -> HUNT, search resumes on the following edge's window.
- Reset and a byte completion in the same cycle: reset wins.
- `valid_out` low for COM, so the downstream parallel path sees COM-as-idle exactly as the transmitter inserts it.

## Structure
- Shared package `phy_pkg`: `COM` constant (8'hBC), state enum {HUNT, LOCK, ACTIVE}, symbol width constant 8. Transmitter uses the same `COM`.
- One natural sub-module: `sp_shift_reg` (8-bit MSB-first shift register exposing the window `w`, asynchronous active-low clear). FSM, counters and output registers in the top module.

## Test plan
- Assert `reset`=0 mid-byte with lane ACTIVE -> all outputs 0 immediately (no clock needed); after release, `active` stays 0 until 4 new COMs.
- 3 junk bits (101) then BC,BC,BC,BC -> `active` rises at the edge sampling the 4th BC's last bit; no `byte_strobe` during alignment.
- Aligned, send EE, CC -> `out`=8'hEE `valid_out`=1 strobe, then 8 cycles later `out`=8'hCC `valid_out`=1 strobe.
- Aligned, send BC between DD and 99 -> `out`=8'hBC `valid_out`=0 with strobe; neighbors `valid_out`=1.
- BC,BC,BC then 55 -> back to HUNT, `active`=0; then BC×4 -> `active`=1.
- Stream 0B,C0,00 (false COM across boundary) -> no lock persists (HUNT after next boundary), `active`=0; then BC×4 aligns at correct phase.
